// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path: FSM state encoding, parity
// type codes, the legal oversampling prescale values and a parity helper.
// -----------------------------------------------------------------------------
package uart_pkg;

    // Receive FSM states. The encoding is fixed so state can be probed
    // and compared against other tools by value.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    // Parity type select values for PAR_TYP.
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Legal oversampling ratios (clocks per bit).
    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    // Parity bit a transmitter would send for data whose XOR-reduction is
    // data_xor: even parity repeats the XOR, odd parity inverts it.
    function automatic logic expected_parity(input logic data_xor,
                                             input logic par_typ);
        return data_xor ^ (par_typ == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// Captures the synchronised serial line three times around the middle of
// each bit (edge P/2-1, P/2, P/2+1), presents the 2-of-3 majority, and flags
// the decision point (edge P/2+2) at which the majority is final.
//
// Ports:
//   clk_i       oversampling clock
//   rst_ni      asynchronous active-low reset
//   rx_i        synchronised serial line
//   edge_cnt_i  position within the current bit, 0..P-1
//   prescale_i  clocks per bit (P) for the frame in progress
//   bit_o       majority-voted bit value
//   dec_vld_o   high for the one cycle where bit_o is the bit's decision
// -----------------------------------------------------------------------------
module uart_rx_sampler #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rx_i,
    input  logic [PRESCALE_W-1:0] edge_cnt_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic                  bit_o,
    output logic                  dec_vld_o
);

    logic [PRESCALE_W-1:0] half;
    logic                  smp0_q;
    logic                  smp1_q;
    logic                  smp2_q;

    assign half = prescale_i >> 1;

    // Samples reset to the idle line level so a stray vote before the first
    // real capture reads as "line high".
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            smp0_q <= 1'b1;
            smp1_q <= 1'b1;
            smp2_q <= 1'b1;
        end else begin
            if (edge_cnt_i == half - PRESCALE_W'(1)) smp0_q <= rx_i;
            if (edge_cnt_i == half)                  smp1_q <= rx_i;
            if (edge_cnt_i == half + PRESCALE_W'(1)) smp2_q <= rx_i;
        end
    end

    // All three samples are registered by edge P/2+2, so the vote taken then
    // belongs entirely to the current bit.
    assign bit_o     = (smp0_q & smp1_q) | (smp0_q & smp2_q) | (smp1_q & smp2_q);
    assign dec_vld_o = (edge_cnt_i == half + PRESCALE_W'(2));

endmodule

// File: rtl/uart_rx_frame.sv
// -----------------------------------------------------------------------------
// uart_rx_frame
// Oversampling UART receiver. Synchronises RX_IN, finds the start bit,
// majority-votes every bit, shifts data in LSB-first, checks optional parity
// and the stop bit, and reports each frame with a one-cycle strobe.
//
// Ports:
//   CLK         oversampling clock
//   Reset       asynchronous active-low reset
//   RX_IN       asynchronous serial input, idles high
//   Prescale    clocks per bit (8, 16 or 32), latched at start detection
//   PAR_EN      1 = frame carries a parity bit, latched at start detection
//   PAR_TYP     0 = even, 1 = odd parity, latched at start detection
//   P_DATA      last correctly received word
//   Data_Valid  one-cycle strobe when P_DATA is updated
//   Par_Err     one-cycle strobe for a parity failure
//   Stp_Err     one-cycle strobe for a low stop bit
// -----------------------------------------------------------------------------
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stp_Err
);

    localparam int               BIT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    // Synchroniser
    logic sync1_q;
    logic rx_s_q;

    // NOTE: every flop here is written with non-blocking assignments so all
    // registers update together at the clock edge, independent of the order
    // the statements appear in.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= RX_IN;
            rx_s_q  <= sync1_q;
        end
    end

    // Frame state
    rx_state_e             state_q;
    logic [PRESCALE_W-1:0] edge_cnt_q;
    logic [PRESCALE_W-1:0] edge_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [PRESCALE_W-1:0] presc_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_bad_q;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  data_valid_q;
    logic                  par_err_q;
    logic                  stp_err_q;

    logic                  edge_last;
    logic                  smp_bit;
    logic                  dec_vld;

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .clk_i      (CLK),
        .rst_ni     (Reset),
        .rx_i       (rx_s_q),
        .edge_cnt_i (edge_cnt_q),
        .prescale_i (presc_q),
        .bit_o      (smp_bit),
        .dec_vld_o  (dec_vld)
    );

    // Position within the bit wraps at P-1 so the next bit starts at 0.
    assign edge_last  = (edge_cnt_q == presc_q - PRESCALE_W'(1));
    assign edge_cnt_d = edge_last ? '0 : edge_cnt_q + PRESCALE_W'(1);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q      <= ST_IDLE;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            presc_q      <= PRESCALE_W'(PRESCALE_8);
            par_en_q     <= 1'b0;
            par_typ_q    <= PAR_EVEN;
            par_bad_q    <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            // Strobes default low every cycle; only the STOP decision raises
            // them, which bounds each one to a single cycle.
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    edge_cnt_q <= '0;
                    bit_cnt_q  <= '0;
                    if (!rx_s_q) begin
                        // This cycle is edge 0 of the start bit, so the
                        // counter continues from 1.
                        state_q    <= ST_START;
                        edge_cnt_q <= PRESCALE_W'(1);
                        presc_q    <= Prescale;
                        par_en_q   <= PAR_EN;
                        par_typ_q  <= PAR_TYP;
                        par_bad_q  <= 1'b0;
                    end
                end

                ST_START: begin
                    if (dec_vld && smp_bit) begin
                        // Line was back high at mid-bit: a glitch, not a start.
                        state_q    <= ST_IDLE;
                        edge_cnt_q <= '0;
                    end else begin
                        edge_cnt_q <= edge_cnt_d;
                        if (edge_last) state_q <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    edge_cnt_q <= edge_cnt_d;
                    if (dec_vld) shift_q <= {smp_bit, shift_q[DATA_WIDTH-1:1]};
                    if (edge_last) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_q <= '0;
                            state_q   <= par_en_q ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        end
                    end
                end

                ST_PARITY: begin
                    edge_cnt_q <= edge_cnt_d;
                    if (dec_vld) par_bad_q <= (smp_bit != expected_parity(^shift_q, par_typ_q));
                    if (edge_last) state_q <= ST_STOP;
                end

                ST_STOP: begin
                    edge_cnt_q <= edge_cnt_d;
                    // Leaving at mid-stop leaves half a bit to spot a start
                    // bit that follows with no idle time.
                    if (dec_vld) begin
                        state_q    <= ST_IDLE;
                        edge_cnt_q <= '0;
                        par_err_q  <= par_bad_q;
                        stp_err_q  <= ~smp_bit;
                        if (smp_bit && !par_bad_q) begin
                            p_data_q     <= shift_q;
                            data_valid_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q    <= ST_IDLE;
                    edge_cnt_q <= '0;
                end
            endcase
        end
    end

    assign P_DATA     = p_data_q;
    assign Data_Valid = data_valid_q;
    assign Par_Err    = par_err_q;
    assign Stp_Err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
`timescale 1ns/1ps
module tb_uart_rx_frame;
    import uart_pkg::*;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          rx      = 1'b1;
    logic [PW-1:0] presc   = PW'(PRESCALE_8);
    logic          par_en  = 1'b0;
    logic          par_typ = PAR_EVEN;
    logic [DW-1:0] p_data;
    logic          dv;
    logic          pe;
    logic          se;

    uart_rx_frame #(
        .DATA_WIDTH (DW),
        .PRESCALE_W (PW)
    ) dut (
        .CLK        (clk),
        .Reset      (rst_n),
        .RX_IN      (rx),
        .Prescale   (presc),
        .PAR_EN     (par_en),
        .PAR_TYP    (par_typ),
        .P_DATA     (p_data),
        .Data_Valid (dv),
        .Par_Err    (pe),
        .Stp_Err    (se)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: one entry per strobe cycle the DUT should produce.
    typedef struct {
        logic [DW-1:0] data;
        logic          dv;
        logic          pe;
        logic          se;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_strobe = 0;
    int   last_dv  = 0;
    int   prev_dv  = 0;

    task automatic expect_ev(input logic [DW-1:0] d, input logic v, input logic p, input logic s);
        exp_t e;
        e.data = d; e.dv = v; e.pe = p; e.se = s;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && (dv || pe || se)) begin
            n_strobe++;
            if (dv) begin
                prev_dv = last_dv;
                last_dv = cyc;
            end
            if (sb_q.size() == 0) begin
                check("unexpected_strobe", {29'd0, dv, pe, se}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("data_valid", dv, mon_e.dv);
                check("par_err", pe, mon_e.pe);
                check("stp_err", se, mon_e.se);
                check("p_data", p_data, mon_e.data);
            end
        end
    end

    // Driving happens on falling edges; each task leaves the caller on one.
    task automatic drive_bit(input logic b, input int n);
        rx = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        drive_bit(1'b1, n);
    endtask

    // glitch >= 0 inverts the line for one clock at edge P/2 of that data bit.
    task automatic send_frame(input logic [DW-1:0] d, input int p, input logic pen,
                              input logic pbit, input logic stop_b, input int glitch,
                              output int t0);
        t0 = cyc;
        drive_bit(1'b0, p);
        for (int i = 0; i < DW; i++) begin
            if (i == glitch) begin
                drive_bit(d[i], p / 2);
                drive_bit(~d[i], 1);
                drive_bit(d[i], p - p / 2 - 1);
            end else begin
                drive_bit(d[i], p);
            end
        end
        if (pen) drive_bit(pbit, p);
        drive_bit(stop_b, p);
    endtask

    int            t0;
    int            snap;
    logic [DW-1:0] d;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_p_data", p_data, 32'd0);
        check("rst_dv", dv, 32'd0);
        check("rst_pe", pe, 32'd0);
        check("rst_se", se, 32'd0);
        rst_n = 1'b1;
        idle(5);

        // Even parity, 0xA5: strobe lands 10.5 bit times + sync/latency later.
        presc = PW'(PRESCALE_8); par_en = 1'b1; par_typ = PAR_EVEN;
        expect_ev(8'hA5, 1'b1, 1'b0, 1'b0);
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, -1, t0);
        idle(24);
        check("t1_latency", last_dv - t0, 32'd89);
        check("t1_sb_empty", sb_q.size(), 32'd0);
        check("t1_p_data", p_data, 32'hA5);

        // Two-cycle low glitch on an idle line must be rejected silently.
        presc = PW'(PRESCALE_16);
        snap  = n_strobe;
        drive_bit(1'b0, 2);
        idle(48);
        check("t2_no_strobe", n_strobe, snap);
        check("t2_p_data", p_data, 32'hA5);

        // Odd parity expected (0x3C has four ones -> 1), send 0.
        presc = PW'(PRESCALE_8); par_en = 1'b1; par_typ = PAR_ODD;
        expect_ev(8'hA5, 1'b0, 1'b1, 1'b0);
        send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b1, -1, t0);
        idle(24);
        check("t3_sb_empty", sb_q.size(), 32'd0);
        check("t3_p_data", p_data, 32'hA5);

        // No parity, low stop bit.
        par_en = 1'b0; par_typ = PAR_EVEN;
        expect_ev(8'hA5, 1'b0, 1'b0, 1'b1);
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, -1, t0);
        idle(24);
        check("t4_sb_empty", sb_q.size(), 32'd0);
        check("t4_p_data", p_data, 32'hA5);

        // Back-to-back frames, zero idle, P=32.
        presc = PW'(PRESCALE_32);
        expect_ev(8'hAA, 1'b1, 1'b0, 1'b0);
        expect_ev(8'hBB, 1'b1, 1'b0, 1'b0);
        send_frame(8'hAA, 32, 1'b0, 1'b0, 1'b1, -1, t0);
        send_frame(8'hBB, 32, 1'b0, 1'b0, 1'b1, -1, t0);
        idle(96);
        check("t5_spacing", last_dv - prev_dv, 32'd320);
        check("t5_sb_empty", sb_q.size(), 32'd0);
        check("t5_p_data", p_data, 32'hBB);

        // Single-cycle high glitch at mid-bit of data bit 3 (a true 0).
        presc = PW'(PRESCALE_16);
        expect_ev(8'h37, 1'b1, 1'b0, 1'b0);
        send_frame(8'h37, 16, 1'b0, 1'b0, 1'b1, 3, t0);
        idle(48);
        check("t6_sb_empty", sb_q.size(), 32'd0);
        check("t6_p_data", p_data, 32'h37);

        // Reset in the middle of the data bits.
        presc = PW'(PRESCALE_8);
        d = 8'h0D;
        drive_bit(1'b0, 8);
        for (int i = 0; i < 3; i++) drive_bit(d[i], 8);
        rst_n = 1'b0;
        rx    = 1'b1;
        #1;
        check("t7_rst_p_data", p_data, 32'd0);
        check("t7_rst_dv", dv, 32'd0);
        check("t7_rst_pe", pe, 32'd0);
        check("t7_rst_se", se, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(40);
        expect_ev(8'hC3, 1'b1, 1'b0, 1'b0);
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, -1, t0);
        idle(24);
        check("t7_sb_empty", sb_q.size(), 32'd0);
        check("t7_p_data", p_data, 32'hC3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
